muxn_stream: RTL
================

# muxn_stream

Parametrised N-to-1 streaming multiplexer with a registered output stage and valid/ready handshakes on every channel. It generalises the combinational 4:1 select tree into a sequential block that supports two selection modes: fixed select (driven by `sel`) and round-robin arbitration across all requesting channels. It sits between multiple producer streams and a single consumer in the datapath, and reports which channel each output word came from.

## Interface
Parameters:
- `N_IN`, default 4, number of input channels; legal range 2..16, power of two not required.
- `WIDTH`, default 8, data width per channel in bits.
- `SW`, default `$clog2(N_IN)`, width of the select and source fields (derived; do not override).

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_data`  input  N_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_valid`  input  N_IN  per-channel valid.
- `in_ready`  output  N_IN  per-channel ready; combinational.
- `rr_en`  input  1  1 = round-robin mode, 0 = fixed-select mode.
- `sel`  input  SW  channel used in fixed-select mode.
- `out_data`  output  WIDTH  registered output data.
- `out_valid`  output  1  registered output valid.
- `out_ready`  input  1  consumer ready.
- `out_src`  output  SW  registered index of the channel that produced `out_data`.

## Operation
- **Output register:** one entry holding `out_data`, `out_src` and `out_valid`.
- **Load enable:** `load_en = !out_valid | out_ready`. The register accepts a new word whenever it is empty or is being drained in the same cycle.
- **Grant, fixed mode (`rr_en=0`):** `grant = onehot(sel)` when `in_valid[sel]` is 1 and `sel < N_IN`; otherwise no grant. An out-of-range `sel` never grants and never asserts any `in_ready`.
- **Grant, round-robin mode (`rr_en=1`):** search channels `ptr, ptr+1, …` modulo N_IN. The first channel with `in_valid` set wins.
- **Ready:** `in_ready[i] = load_en & grant[i]`. At most one `in_ready` bit is high in any cycle. `in_ready` is never asserted to a channel whose `in_valid` is low.
- **Transfer:** channel i transfers when `in_valid[i] & in_ready[i]`. On that edge:
  - `out_data <= in_data[i]`
  - `out_src <= i`
  - `out_valid <= 1`
- **Drain with no refill:** if `out_valid & out_ready` and nothing transfers, then `out_valid <= 0`. `out_data` and `out_src` hold their values.
- **Hold:** while `out_valid & !out_ready`, `out_data` and `out_src` stay stable and all `in_ready` bits are 0.
- **Pointer `ptr`** (SW bits, range 0..N_IN-1):
  - Updates only on a transfer with `rr_en=1`: `ptr <= (granted+1) mod N_IN`. It wraps from N_IN-1 to 0, including when N_IN is not a power of two.
  - In fixed mode `ptr` is unchanged.
  - Switching `rr_en` takes effect on the next grant decision, with no flush.
- **Reset values** (asynchronous on `rst`, regardless of clock state):
  - `out_valid = 0`, `out_data = 0`, `out_src = 0`, `ptr = 0`.
  - `in_ready` is all 0 while `rst` is high.
  - An in-flight output word is discarded.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 word per cycle while `out_ready` is held at 1.
- Combinational paths:
  - `out_ready → in_ready` (through `load_en`).
  - `in_valid`/`sel`/`rr_en → in_ready` (through the grant logic).
  - There is no combinational path from any input to `out_data`, `out_valid` or `out_src`.
- Simultaneous drain and load in the same cycle: the new word replaces the old one, and `out_valid` stays 1.
- Deassertion of `rst` is assumed synchronised externally. The first grant may occur on the first rising edge after `rst` falls.

## Test plan
- **Reset:** assert `rst` mid-stream while `out_valid=1`, with no clock edge.
  - Expect `out_valid`, `out_data` and `out_src` to drop to 0 immediately, and `in_ready` to go to 0.
  - After release, the first round-robin grant goes to channel 0.
- **Fixed mode, back-to-back:** N_IN=4, `rr_en=0`, `sel=2`, `in_valid=4'b1111`, `in_data[2]` counting 0x10, 0x11, …, `out_ready=1`.
  - Expect `out_data` 0x10, 0x11, … on consecutive cycles, `out_src=2`, and only `in_ready[2]` ever high.
- **Round-robin fairness:** `rr_en=1`, all four channels valid, `out_ready=1`.
  - Expect `out_src` sequence 0, 1, 2, 3, 0, 1, with each channel receiving exactly one `in_ready` per 4 cycles.
- **Sparse requests and wrap:** `ptr=3`, `in_valid=4'b0101`.
  - Expect a grant to channel 0, then channel 2, then channel 0.
  - Then build with N_IN=3 and check that `ptr` wraps from 2 to 0.
- **Backpressure:** `out_ready=0` for 5 cycles while `out_valid=1` (data 0xA5).
  - Expect `out_data` to hold 0xA5, `in_ready` to stay all 0, and `ptr` to stay frozen.
  - When `out_ready` rises, expect a drain and a refill in the same cycle.
- **Out-of-range select:** N_IN=3, `rr_en=0`, `sel=3`, all channels valid.
  - Expect no `in_ready` and `out_valid` to stay 0.

Source files
------------

// File: rtl/muxn_stream.sv
// muxn_stream: N-to-1 streaming multiplexer with a single registered output slot.
//
// Selection modes:
//   rr_en = 0 : fixed select, channel `sel` is granted when it is valid
//   rr_en = 1 : round-robin, first valid channel searching upward from ptr
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_data    N_IN*WIDTH packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, at most one bit high)
//   rr_en      round-robin enable
//   sel        fixed-mode channel select
//   out_data   registered output data
//   out_valid  registered output valid
//   out_ready  consumer ready
//   out_src    registered index of the channel that produced out_data
module muxn_stream #(
    parameter int N_IN  = 4,
    parameter int WIDTH = 8,
    parameter int SW    = $clog2(N_IN)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [N_IN-1:0]       in_valid,
    output logic [N_IN-1:0]       in_ready,
    input  logic                  rr_en,
    input  logic [SW-1:0]         sel,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SW-1:0]         out_src
);

    localparam int NPAD = 1 << SW;

    logic [WIDTH-1:0] chan [N_IN];
    logic [NPAD-1:0]  valid_pad;
    logic             load_en;
    logic             fixed_hit;
    logic             rr_hit;
    logic [SW-1:0]    rr_idx;
    logic [SW:0]      cand_sum;
    logic [SW-1:0]    cand;
    logic             grant_hit;
    logic [SW-1:0]    grant_idx;
    logic             xfer;
    logic [SW-1:0]    ptr;
    logic [SW-1:0]    next_ptr;

    for (genvar g = 0; g < N_IN; g++) begin : g_chan
        assign chan[g] = in_data[g*WIDTH +: WIDTH];
    end

    assign load_en = !out_valid || out_ready;

    // Padding in_valid to 2**SW bits makes an out-of-range sel read a
    // zero valid, so it can never grant.
    always_comb begin
        valid_pad = '0;
        valid_pad[N_IN-1:0] = in_valid;
        fixed_hit = valid_pad[sel];
    end

    // Round-robin search ptr, ptr+1, ... modulo N_IN; the wrap is done by
    // subtraction so non-power-of-two N_IN works.
    always_comb begin
        rr_hit   = 1'b0;
        rr_idx   = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = 0; k < N_IN; k++) begin
            cand_sum = {1'b0, ptr} + (SW+1)'(k);
            if (cand_sum >= (SW+1)'(N_IN)) begin
                cand_sum = cand_sum - (SW+1)'(N_IN);
            end
            cand = cand_sum[SW-1:0];
            if (!rr_hit && in_valid[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
        end
    end

    always_comb begin
        if (rr_en) begin
            grant_hit = rr_hit;
            grant_idx = rr_idx;
        end else begin
            grant_hit = fixed_hit;
            grant_idx = sel;
        end
    end

    assign xfer = !rst && load_en && grant_hit;

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_ready[i] = xfer && (grant_idx == SW'(i));
        end
    end

    assign next_ptr = (grant_idx == SW'(N_IN - 1)) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else begin
            if (xfer) begin
                out_data  <= chan[grant_idx];
                out_src   <= grant_idx;
                out_valid <= 1'b1;
                if (rr_en) begin
                    ptr <= next_ptr;
                end
            end else if (out_ready) begin
                // drain with no refill; data and source are left as they were
                out_valid <= 1'b0;
            end
        end
    end

endmodule
